// File: rtl/cs_next_address_pkg.sv
// Shared definitions for the microsequencer next-address stage:
// sequencing op encodings, FSM state encodings and the default address width.
package cs_next_address_pkg;

   localparam int CSAI_DATAWIDTH_DEF = 11;

   typedef enum logic [2:0] {
      OP_NEXT     = 3'b000,
      OP_JUMP     = 3'b001,
      OP_CJUMP    = 3'b010,
      OP_CALL     = 3'b011,
      OP_RET      = 3'b100,
      OP_DISPATCH = 3'b101,
      OP_HOLD     = 3'b110,
      OP_RSVD     = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_DECIDE = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

endpackage

// File: rtl/cs_next_address_if.sv
// Bus between the next-address sequencer (master) and the datapath /
// control-store side (slave).
//
// Handshake: Valid is high exactly while the sequencer sits in DECIDE, meaning
// CSAddress, CSAI and the microinstruction fields are stable. The datapath
// raises ACK when it is ready; a step completes on a rising edge where
// Valid && ACK are both high. ACK is ignored whenever Valid is low.
interface cs_next_address_if
   import cs_next_address_pkg::*;
#(
   parameter int CSAI_DATAWIDTH = CSAI_DATAWIDTH_DEF
) ();

   logic                      CS_NEXT_ADDRESS_ACK;
   logic [CSAI_DATAWIDTH-1:0] CS_NEXT_ADDRESS_CSAI_InBus;
   logic [CSAI_DATAWIDTH-1:0] CS_NEXT_ADDRESS_Branch_InBus;
   logic [2:0]                CS_NEXT_ADDRESS_Op_InBus;
   logic [1:0]                CS_NEXT_ADDRESS_CondSel_InBus;
   logic                      CS_NEXT_ADDRESS_CondPol_In;
   logic [3:0]                CS_NEXT_ADDRESS_Flags_InBus;
   logic [CSAI_DATAWIDTH-1:0] CS_NEXT_ADDRESS_Dispatch_InBus;
   logic [CSAI_DATAWIDTH-1:0] CS_NEXT_ADDRESS_CSAddress_OutBus;
   logic                      CS_NEXT_ADDRESS_IncAck_Out;
   logic                      CS_NEXT_ADDRESS_Valid_Out;
   logic                      CS_NEXT_ADDRESS_Fault_Out;
   state_t                    dbg_state;

   modport master (
      input  CS_NEXT_ADDRESS_ACK,
      input  CS_NEXT_ADDRESS_CSAI_InBus,
      input  CS_NEXT_ADDRESS_Branch_InBus,
      input  CS_NEXT_ADDRESS_Op_InBus,
      input  CS_NEXT_ADDRESS_CondSel_InBus,
      input  CS_NEXT_ADDRESS_CondPol_In,
      input  CS_NEXT_ADDRESS_Flags_InBus,
      input  CS_NEXT_ADDRESS_Dispatch_InBus,
      output CS_NEXT_ADDRESS_CSAddress_OutBus,
      output CS_NEXT_ADDRESS_IncAck_Out,
      output CS_NEXT_ADDRESS_Valid_Out,
      output CS_NEXT_ADDRESS_Fault_Out,
      output dbg_state
   );

   modport slave (
      output CS_NEXT_ADDRESS_ACK,
      output CS_NEXT_ADDRESS_CSAI_InBus,
      output CS_NEXT_ADDRESS_Branch_InBus,
      output CS_NEXT_ADDRESS_Op_InBus,
      output CS_NEXT_ADDRESS_CondSel_InBus,
      output CS_NEXT_ADDRESS_CondPol_In,
      output CS_NEXT_ADDRESS_Flags_InBus,
      output CS_NEXT_ADDRESS_Dispatch_InBus,
      input  CS_NEXT_ADDRESS_CSAddress_OutBus,
      input  CS_NEXT_ADDRESS_IncAck_Out,
      input  CS_NEXT_ADDRESS_Valid_Out,
      input  CS_NEXT_ADDRESS_Fault_Out,
      input  dbg_state
   );

endinterface

// File: rtl/cs_return_stack.sv
// Return-address LIFO for micro-subroutine CALL/RET. The pointer counts
// 0..DEPTH so full and empty are distinguishable without an extra flag.
// Push while full and pop while empty are ignored here; the sequencer turns
// them into a fault before they reach this block.
module cs_return_stack #(
   parameter int W     = 11,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] top_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] sp_q, sp_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] top_idx;

   assign full_o  = (sp_q == PW'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign wr_idx  = sp_q[AW-1:0];
   // At sp == DEPTH the low bits wrap to 0, so minus one lands on DEPTH-1.
   assign top_idx = sp_q[AW-1:0] - AW'(1);
   assign top_o   = mem_q[top_idx];

   // Next pointer: one step up on push, one down on pop, guarded at the ends.
   always_comb begin
      sp_d = sp_q;
      if (push_i && !full_o) begin
         sp_d = sp_q + PW'(1);
      end else if (pop_i && !empty_o) begin
         sp_d = sp_q - PW'(1);
      end
   end

   // Stack pointer register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Entry storage; contents survive reset, only the pointer is cleared.
   always_ff @(posedge clk_i) begin
      if (!rst_i && push_i && !full_o) begin
         mem_q[wr_idx] <= data_i;
      end
   end

endmodule

// File: rtl/cs_next_address.sv
// Microsequencer next-address stage. Holds the registered control-store
// address and, once per microinstruction (SETTLE then DECIDE), picks the next
// one: sequential, jump, conditional jump, call/return or opcode dispatch.
// Stack misuse parks the sequencer in FAULT until reset.
module cs_next_address
   import cs_next_address_pkg::*;
#(
   parameter int CSAI_DATAWIDTH = CSAI_DATAWIDTH_DEF,
   parameter int STACK_DEPTH    = 4
) (
   input  logic              CS_NEXT_ADDRESS_CLOCK_50,
   input  logic              CS_NEXT_ADDRESS_RESET_InHigh,
   cs_next_address_if.master bus
);

   state_t                    state_q, state_d;
   logic [CSAI_DATAWIDTH-1:0] addr_q, addr_d;
   logic                      push, pop;
   logic                      take;
   logic [CSAI_DATAWIDTH-1:0] stk_top;
   logic                      stk_full, stk_empty;

   // Return addresses are always the CSAI present during DECIDE.
   cs_return_stack #(
      .W     (CSAI_DATAWIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk_i   (CS_NEXT_ADDRESS_CLOCK_50),
      .rst_i   (CS_NEXT_ADDRESS_RESET_InHigh),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (bus.CS_NEXT_ADDRESS_CSAI_InBus),
      .top_o   (stk_top),
      .full_o  (stk_full),
      .empty_o (stk_empty)
   );

   assign take = bus.CS_NEXT_ADDRESS_Flags_InBus[bus.CS_NEXT_ADDRESS_CondSel_InBus]
                 ^ bus.CS_NEXT_ADDRESS_CondPol_In;

   // Next-state, next-address and stack-control decode.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      push    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         ST_SETTLE: begin
            state_d = ST_DECIDE;
         end
         ST_DECIDE: begin
            if (bus.CS_NEXT_ADDRESS_ACK) begin
               state_d = ST_SETTLE;
               case (op_t'(bus.CS_NEXT_ADDRESS_Op_InBus))
                  OP_JUMP:     addr_d = bus.CS_NEXT_ADDRESS_Branch_InBus;
                  OP_CJUMP:    addr_d = take ? bus.CS_NEXT_ADDRESS_Branch_InBus
                                             : bus.CS_NEXT_ADDRESS_CSAI_InBus;
                  OP_CALL: begin
                     if (stk_full) begin
                        state_d = ST_FAULT;
                     end else begin
                        push   = 1'b1;
                        addr_d = bus.CS_NEXT_ADDRESS_Branch_InBus;
                     end
                  end
                  OP_RET: begin
                     if (stk_empty) begin
                        state_d = ST_FAULT;
                     end else begin
                        pop    = 1'b1;
                        addr_d = stk_top;
                     end
                  end
                  OP_DISPATCH: addr_d = bus.CS_NEXT_ADDRESS_Dispatch_InBus;
                  OP_HOLD:     addr_d = addr_q;
                  default:     addr_d = bus.CS_NEXT_ADDRESS_CSAI_InBus;
               endcase
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_SETTLE;
         end
      endcase
   end

   // State and address registers; reset wins over any step in flight.
   always_ff @(posedge CS_NEXT_ADDRESS_CLOCK_50) begin
      if (CS_NEXT_ADDRESS_RESET_InHigh) begin
         state_q <= ST_SETTLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   assign bus.CS_NEXT_ADDRESS_CSAddress_OutBus = addr_q;
   assign bus.CS_NEXT_ADDRESS_IncAck_Out       = (state_q != ST_FAULT);
   assign bus.CS_NEXT_ADDRESS_Valid_Out        = (state_q == ST_DECIDE);
   assign bus.CS_NEXT_ADDRESS_Fault_Out        = (state_q == ST_FAULT);
   assign bus.dbg_state                        = state_q;

endmodule

// File: tb/tb_cs_next_address.sv
// Bench for the microsequencer next-address stage, with a behavioural
// incrementer feeding CSAI back from the registered address.
module tb_cs_next_address;
   import cs_next_address_pkg::*;

   localparam int W = 11;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] br;
      logic [1:0]   sel;
      logic         pol;
      logic [3:0]   flags;
      logic [W-1:0] disp;
      logic [W-1:0] exp_addr;
      logic         exp_fault;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [W:0] exp_q[$];
   vec_t vecs[15];

   cs_next_address_if #(.CSAI_DATAWIDTH(W)) bus ();

   cs_next_address #(
      .CSAI_DATAWIDTH (W),
      .STACK_DEPTH    (4)
   ) dut (
      .CS_NEXT_ADDRESS_CLOCK_50     (clk),
      .CS_NEXT_ADDRESS_RESET_InHigh (rst),
      .bus                          (bus)
   );

   // clock
   always #5 clk = ~clk;

   // incrementer model: registers CSAddress+1 while its ACK is high
   always @(posedge clk) begin
      if (rst)
         bus.CS_NEXT_ADDRESS_CSAI_InBus <= '0;
      else if (bus.CS_NEXT_ADDRESS_IncAck_Out)
         bus.CS_NEXT_ADDRESS_CSAI_InBus <= bus.CS_NEXT_ADDRESS_CSAddress_OutBus + 11'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ack, input logic [2:0] op, input logic [W-1:0] br,
                        input logic [1:0] sel, input logic pol, input logic [3:0] flags,
                        input logic [W-1:0] disp);
      bus.CS_NEXT_ADDRESS_ACK            = ack;
      bus.CS_NEXT_ADDRESS_Op_InBus       = op;
      bus.CS_NEXT_ADDRESS_Branch_InBus   = br;
      bus.CS_NEXT_ADDRESS_CondSel_InBus  = sel;
      bus.CS_NEXT_ADDRESS_CondPol_In     = pol;
      bus.CS_NEXT_ADDRESS_Flags_InBus    = flags;
      bus.CS_NEXT_ADDRESS_Dispatch_InBus = disp;
   endtask

   task automatic wait_decide(input string name);
      int n = 0;
      while (bus.CS_NEXT_ADDRESS_Valid_Out !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (bus.CS_NEXT_ADDRESS_Valid_Out !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: got Valid=%b expected 1 within 8 cycles", name,
                  bus.CS_NEXT_ADDRESS_Valid_Out);
      end
   endtask

   // One microinstruction step: drive in DECIDE, check after the edge (SETTLE)
   // and again one cycle later (back in DECIDE, or still FAULT).
   task automatic step(input string name, input logic [2:0] op, input logic [W-1:0] br,
                       input logic [1:0] sel, input logic pol, input logic [3:0] flags,
                       input logic [W-1:0] disp, input logic [W-1:0] exp_addr,
                       input logic exp_fault);
      logic [W:0] e;
      wait_decide(name);
      drive(1'b1, op, br, sel, pol, flags, disp);
      exp_q.push_back({exp_fault, exp_addr});
      @(negedge clk);
      bus.CS_NEXT_ADDRESS_ACK = 1'b0;
      e = exp_q.pop_front();
      check({name, " addr"},   bus.CS_NEXT_ADDRESS_CSAddress_OutBus, e[W-1:0]);
      check({name, " fault"},  bus.CS_NEXT_ADDRESS_Fault_Out, e[W]);
      check({name, " valid"},  bus.CS_NEXT_ADDRESS_Valid_Out, 1'b0);
      check({name, " incack"}, bus.CS_NEXT_ADDRESS_IncAck_Out, !e[W]);
      @(negedge clk);
      check({name, " valid+1"}, bus.CS_NEXT_ADDRESS_Valid_Out, !e[W]);
      check({name, " addr+1"},  bus.CS_NEXT_ADDRESS_CSAddress_OutBus, e[W-1:0]);
   endtask

   task automatic check_frozen(input string name, input logic [W-1:0] a);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'(OP_JUMP), 11'h777, 2'd0, 1'b0, 4'h0, 11'h0);
         @(negedge clk);
         check({name, " addr"},   bus.CS_NEXT_ADDRESS_CSAddress_OutBus, a);
         check({name, " fault"},  bus.CS_NEXT_ADDRESS_Fault_Out, 1'b1);
         check({name, " incack"}, bus.CS_NEXT_ADDRESS_IncAck_Out, 1'b0);
         check({name, " valid"},  bus.CS_NEXT_ADDRESS_Valid_Out, 1'b0);
      end
      bus.CS_NEXT_ADDRESS_ACK = 1'b0;
   endtask

   task automatic do_reset(input string name);
      drive(1'b0, 3'(OP_NEXT), '0, 2'd0, 1'b0, 4'h0, '0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check({name, " addr"},   bus.CS_NEXT_ADDRESS_CSAddress_OutBus, 11'h000);
      check({name, " fault"},  bus.CS_NEXT_ADDRESS_Fault_Out, 1'b0);
      check({name, " valid"},  bus.CS_NEXT_ADDRESS_Valid_Out, 1'b0);
      check({name, " incack"}, bus.CS_NEXT_ADDRESS_IncAck_Out, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check({name, " decide"}, bus.CS_NEXT_ADDRESS_Valid_Out, 1'b1);
   endtask

   initial begin
      //            op              br      sel   pol   flags    disp     exp      flt
      vecs[0]  = '{3'(OP_NEXT),     11'h000, 2'd0, 1'b0, 4'b0000, 11'h000, 11'h001, 1'b0};
      vecs[1]  = '{3'(OP_NEXT),     11'h000, 2'd0, 1'b0, 4'b0000, 11'h000, 11'h002, 1'b0};
      vecs[2]  = '{3'(OP_NEXT),     11'h000, 2'd0, 1'b0, 4'b0000, 11'h000, 11'h003, 1'b0};
      vecs[3]  = '{3'(OP_JUMP),     11'h7FF, 2'd0, 1'b0, 4'b0000, 11'h000, 11'h7FF, 1'b0};
      vecs[4]  = '{3'(OP_NEXT),     11'h000, 2'd0, 1'b0, 4'b0000, 11'h000, 11'h000, 1'b0};
      vecs[5]  = '{3'(OP_CJUMP),    11'h040, 2'd2, 1'b0, 4'b0100, 11'h000, 11'h040, 1'b0};
      vecs[6]  = '{3'(OP_CJUMP),    11'h200, 2'd2, 1'b1, 4'b0100, 11'h000, 11'h041, 1'b0};
      vecs[7]  = '{3'(OP_JUMP),     11'h010, 2'd0, 1'b0, 4'b0000, 11'h000, 11'h010, 1'b0};
      vecs[8]  = '{3'(OP_CALL),     11'h100, 2'd0, 1'b0, 4'b0000, 11'h000, 11'h100, 1'b0};
      vecs[9]  = '{3'(OP_RET),      11'h000, 2'd0, 1'b0, 4'b0000, 11'h000, 11'h011, 1'b0};
      vecs[10] = '{3'(OP_DISPATCH), 11'h000, 2'd0, 1'b0, 4'b0000, 11'h3A5, 11'h3A5, 1'b0};
      vecs[11] = '{3'(OP_HOLD),     11'h000, 2'd0, 1'b0, 4'b0000, 11'h000, 11'h3A5, 1'b0};
      vecs[12] = '{3'(OP_RSVD),     11'h000, 2'd0, 1'b0, 4'b0000, 11'h000, 11'h3A6, 1'b0};
      vecs[13] = '{3'(OP_CJUMP),    11'h123, 2'd0, 1'b1, 4'b1110, 11'h000, 11'h123, 1'b0};
      vecs[14] = '{3'(OP_CJUMP),    11'h555, 2'd3, 1'b0, 4'b0111, 11'h000, 11'h124, 1'b0};

      rst = 1'b1;
      do_reset("reset");

      for (int i = 0; i < 15; i++) begin
         step($sformatf("vec%0d", i), vecs[i].op, vecs[i].br, vecs[i].sel, vecs[i].pol,
              vecs[i].flags, vecs[i].disp, vecs[i].exp_addr, vecs[i].exp_fault);
      end

      // ACK low for three DECIDE cycles holds the address
      drive(1'b0, 3'(OP_NEXT), '0, 2'd0, 1'b0, 4'h0, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("acklow%0d addr", i), bus.CS_NEXT_ADDRESS_CSAddress_OutBus, 11'h124);
         check($sformatf("acklow%0d valid", i), bus.CS_NEXT_ADDRESS_Valid_Out, 1'b1);
      end
      step("ackrise", 3'(OP_NEXT), '0, 2'd0, 1'b0, 4'h0, '0, 11'h125, 1'b0);

      // fill the stack, unwind it in LIFO order, then underflow
      do_reset("reset2");
      step("callA", 3'(OP_CALL), 11'h100, 2'd0, 1'b0, 4'h0, '0, 11'h100, 1'b0);
      step("callB", 3'(OP_CALL), 11'h200, 2'd0, 1'b0, 4'h0, '0, 11'h200, 1'b0);
      step("callC", 3'(OP_CALL), 11'h300, 2'd0, 1'b0, 4'h0, '0, 11'h300, 1'b0);
      step("callD", 3'(OP_CALL), 11'h400, 2'd0, 1'b0, 4'h0, '0, 11'h400, 1'b0);
      step("retD",  3'(OP_RET),  11'h000, 2'd0, 1'b0, 4'h0, '0, 11'h301, 1'b0);
      step("retC",  3'(OP_RET),  11'h000, 2'd0, 1'b0, 4'h0, '0, 11'h201, 1'b0);
      step("retB",  3'(OP_RET),  11'h000, 2'd0, 1'b0, 4'h0, '0, 11'h101, 1'b0);
      step("retA",  3'(OP_RET),  11'h000, 2'd0, 1'b0, 4'h0, '0, 11'h001, 1'b0);
      step("underflow", 3'(OP_RET), 11'h000, 2'd0, 1'b0, 4'h0, '0, 11'h001, 1'b1);
      check_frozen("uflow_frozen", 11'h001);

      // overflow on the fifth nested call
      do_reset("reset3");
      step("ovf1", 3'(OP_CALL), 11'h100, 2'd0, 1'b0, 4'h0, '0, 11'h100, 1'b0);
      step("ovf2", 3'(OP_CALL), 11'h200, 2'd0, 1'b0, 4'h0, '0, 11'h200, 1'b0);
      step("ovf3", 3'(OP_CALL), 11'h300, 2'd0, 1'b0, 4'h0, '0, 11'h300, 1'b0);
      step("ovf4", 3'(OP_CALL), 11'h400, 2'd0, 1'b0, 4'h0, '0, 11'h400, 1'b0);
      step("ovf5", 3'(OP_CALL), 11'h500, 2'd0, 1'b0, 4'h0, '0, 11'h400, 1'b1);
      check_frozen("ovf_frozen", 11'h400);

      // reset during DECIDE of a CALL commits no push
      do_reset("reset4");
      step("pre_jump", 3'(OP_JUMP), 11'h050, 2'd0, 1'b0, 4'h0, '0, 11'h050, 1'b0);
      wait_decide("midcall");
      drive(1'b1, 3'(OP_CALL), 11'h100, 2'd0, 1'b0, 4'h0, '0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst addr",  bus.CS_NEXT_ADDRESS_CSAddress_OutBus, 11'h000);
      check("midrst fault", bus.CS_NEXT_ADDRESS_Fault_Out, 1'b0);
      check("midrst valid", bus.CS_NEXT_ADDRESS_Valid_Out, 1'b0);
      rst = 1'b0;
      bus.CS_NEXT_ADDRESS_ACK = 1'b0;
      @(negedge clk);
      step("ret_after_rst", 3'(OP_RET), '0, 2'd0, 1'b0, 4'h0, '0, 11'h000, 1'b1);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
